// File: rtl/vr_to_burst.sv
// ============================================================================
// Module      : vr_to_burst
// Description : Buffers a valid/ready sample stream and re-emits it as
//               fixed-length bursts of BURST_LEN beats with a last marker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vr_to_burst #(
    parameter int WIDTH     = 16,
    parameter int BURST_LEN = 8,
    parameter int DEPTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic [WIDTH-1:0]         m_bdata,
    output logic                     m_bvalid,
    input  logic                     m_bready,
    output logic                     m_blast,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(BURST_LEN);

    localparam logic [LW-1:0] C_DEPTH     = LW'(DEPTH);
    localparam logic [LW-1:0] C_BURST_LEN = LW'(BURST_LEN);
    localparam logic [CW-1:0] C_LAST_BEAT = CW'(BURST_LEN - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [LW-1:0]    level_q, level_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    beat_q, beat_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic w_wr;
    logic w_rd;

    // Every output is decoded from registered state only, so no input
    // (in particular m_bready) reaches an output combinationally.
    assign s_ready  = (level_q != C_DEPTH);
    assign m_bvalid = (state_q == BURST);
    assign m_blast  = (state_q == BURST) && (beat_q == C_LAST_BEAT);
    assign m_bdata  = mem_q[rd_ptr_q];
    assign level    = level_q;

    assign w_wr = s_valid && s_ready;
    assign w_rd = m_bvalid && m_bready;

    always_comb begin
        level_d  = level_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        state_d  = state_q;
        beat_d   = beat_q;

        case ({w_wr, w_rd})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        if (w_wr) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (level_q >= C_BURST_LEN) begin
                    state_d = BURST;
                    beat_d  = '0;
                end
            end
            BURST: begin
                if (w_rd) begin
                    if (m_blast) begin
                        // Chain straight into the next burst when enough
                        // samples remain, counting a same-cycle write.
                        beat_d = '0;
                        if (level_d < C_BURST_LEN) begin
                            state_d = IDLE;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            level_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            beat_q   <= beat_d;
        end
    end

    // Storage carries no reset; contents are only observed when valid.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vr_to_burst.sv
// ============================================================================
// Module      : tb_vr_to_burst
// Description : Self-checking bench for vr_to_burst: vector table, directed
//               corner sequences and random traffic against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vr_to_burst;

    localparam int WIDTH = 16;
    localparam int BL    = 8;
    localparam int DEPTH = 16;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] s_data;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] m_bdata;
    logic             m_bvalid;
    logic             m_bready;
    logic             m_blast;
    logic [4:0]       level;

    vr_to_burst #(
        .WIDTH     (WIDTH),
        .BURST_LEN (BL),
        .DEPTH     (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .m_bdata  (m_bdata),
        .m_bvalid (m_bvalid),
        .m_bready (m_bready),
        .m_blast  (m_blast),
        .level    (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    // Reference model: a plain FIFO of accepted samples, the number of beats
    // delivered so far, and what was visible in the previous cycle.
    logic [WIDTH-1:0] q[$];
    int               n_beats;
    bit               prev_valid;
    int               prev_size;

    typedef struct {
        logic             sv;
        logic [WIDTH-1:0] sd;
        logic             br;
        logic             e_sr;
        logic             e_bv;
        logic             e_bl;
        logic [WIDTH-1:0] e_bd;
        logic [4:0]       e_lvl;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        $display("FAIL %s: timed out waiting, got no event, expected event (t=%0t)", name, $time);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        s_valid  = 1'b0;
        s_data   = '0;
        m_bready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst        = 1'b0;
        q.delete();
        n_beats    = 0;
        prev_valid = 1'b0;
        prev_size  = 0;
    endtask

    // One clock cycle: drive inputs, compare DUT against the model, advance.
    task automatic step(input logic sv, input logic [WIDTH-1:0] sd, input logic br,
                        output logic acc);
        bit ev, eb, rd;
        int sz;
        s_valid  = sv;
        s_data   = sd;
        m_bready = br;
        sz = q.size();
        if (n_beats % BL != 0)   ev = 1'b1;
        else if (prev_valid)     ev = (sz >= BL);
        else                     ev = (prev_size >= BL);
        eb = ev && (n_beats % BL == BL - 1);
        check("s_ready",  32'(s_ready),  32'(sz != DEPTH));
        check("m_bvalid", 32'(m_bvalid), 32'(ev));
        check("m_blast",  32'(m_blast),  32'(eb));
        check("level",    32'(level),    32'(sz));
        if (ev) check("m_bdata", 32'(m_bdata), 32'(q[0]));
        acc = sv && (sz != DEPTH);
        rd  = ev && br;
        @(posedge clk);
        prev_valid = ev;
        prev_size  = sz;
        if (acc) q.push_back(sd);
        if (rd) begin
            void'(q.pop_front());
            n_beats++;
        end
        @(negedge clk);
    endtask

    task automatic wait_valid(input string name, input logic br);
        logic acc;
        for (int i = 0; i < 40 && !m_bvalid; i++) step(1'b0, '0, br, acc);
        if (!m_bvalid) timeout_fail(name);
    endtask

    initial begin
        logic             acc;
        logic [WIDTH-1:0] d;

        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_bready = 1'b0;

        // ---- vector table: 8 writes then one full burst -------------------
        for (int i = 0; i < 8; i++)
            vecs[i] = '{1'b1, WIDTH'(i + 1), 1'b1, 1'b1, 1'b0, 1'b0, '0, 5'(i)};
        vecs[8] = '{1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, '0, 5'd8};
        for (int j = 0; j < 8; j++)
            vecs[9 + j] = '{1'b0, '0, 1'b1, 1'b1, 1'b1, (j == 7), WIDTH'(j + 1), 5'(8 - j)};
        vecs[17] = '{1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, '0, 5'd0};

        do_reset();
        for (int i = 0; i < 18; i++) begin
            s_valid  = vecs[i].sv;
            s_data   = vecs[i].sd;
            m_bready = vecs[i].br;
            check($sformatf("vec%0d s_ready", i),  32'(s_ready),  32'(vecs[i].e_sr));
            check($sformatf("vec%0d m_bvalid", i), 32'(m_bvalid), 32'(vecs[i].e_bv));
            check($sformatf("vec%0d m_blast", i),  32'(m_blast),  32'(vecs[i].e_bl));
            check($sformatf("vec%0d level", i),    32'(level),    32'(vecs[i].e_lvl));
            if (vecs[i].e_bv)
                check($sformatf("vec%0d m_bdata", i), 32'(m_bdata), 32'(vecs[i].e_bd));
            @(posedge clk);
            @(negedge clk);
        end

        // ---- 7 samples never form a burst; the 8th does -------------------
        do_reset();
        for (int i = 0; i < 7; i++) step(1'b1, WIDTH'(16'h0050 + i), 1'b1, acc);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, acc);
        check("partial level", 32'(level), 32'd7);
        check("partial m_bvalid", 32'(m_bvalid), 32'd0);
        step(1'b1, 16'h0057, 1'b1, acc);
        for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1, acc);
        check("partial burst beats", 32'(n_beats), 32'd8);

        // ---- fill with downstream stalled, then drain two bursts ----------
        do_reset();
        d = 16'h0100;
        for (int i = 0; i < 22; i++) begin
            step(1'b1, d, 1'b0, acc);
            if (acc) d++;
        end
        check("full level", 32'(level), 32'd16);
        check("full s_ready", 32'(s_ready), 32'd0);
        check("full m_bvalid", 32'(m_bvalid), 32'd1);
        check("full head", 32'(m_bdata), 32'h0100);
        for (int i = 0; i < 40; i++) begin
            step(d < 16'h0114, d, 1'b1, acc);
            if (acc) d++;
        end
        check("drain accepted", 32'(d), 32'h0114);
        check("drain level", 32'(level), 32'd4);

        // ---- continuous input, m_bready toggling each cycle ---------------
        do_reset();
        d = '0;
        for (int c = 0; c < 500 && !(d == 100 && n_beats == 96); c++) begin
            step(d < 100, d, c[0], acc);
            if (acc) d++;
        end
        if (!(d == 100 && n_beats == 96)) timeout_fail("toggle drain");
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, acc);
        check("toggle level", 32'(level), 32'd4);
        check("toggle m_bvalid", 32'(m_bvalid), 32'd0);

        // ---- reset after the third beat of a burst ------------------------
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, WIDTH'(16'h0300 + i), 1'b0, acc);
        wait_valid("rst burst start", 1'b0);
        for (int i = 0; i < 20 && n_beats < 3; i++) step(1'b0, '0, 1'b1, acc);
        do_reset();
        check("rst m_bvalid", 32'(m_bvalid), 32'd0);
        check("rst level", 32'(level), 32'd0);
        check("rst s_ready", 32'(s_ready), 32'd1);
        for (int i = 0; i < 8; i++) step(1'b1, WIDTH'(16'h0400 + i), 1'b0, acc);
        wait_valid("rst fresh burst", 1'b0);
        check("rst fresh head", 32'(m_bdata), 32'h0400);
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, acc);

        // ---- last-beat read coinciding with a write at level 8 ------------
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, WIDTH'(16'h0500 + i), 1'b0, acc);
        wait_valid("b2b burst start", 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, WIDTH'(16'h0508 + i), 1'b1, acc);
        check("b2b level", 32'(level), 32'd8);
        check("b2b m_bvalid", 32'(m_bvalid), 32'd1);
        check("b2b head", 32'(m_bdata), 32'h0508);
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, acc);

        // ---- random traffic against the model ------------------------------
        do_reset();
        for (int i = 0; i < 800; i++)
            step($urandom_range(0, 9) < 7, WIDTH'($urandom), $urandom_range(0, 9) < 6, acc);
        for (int i = 0; i < 40; i++) step(1'b0, '0, 1'b1, acc);
        check("random final level", 32'(level), 32'(q.size()));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
